gnr_attractor_ctrl: RTL and testbench
=====================================

# gnr_attractor_ctrl

Sequencer for the dual-trajectory gene-regulatory-network node array. It initialises all nodes, then pulses the two update streams to run Floyd cycle detection. Stream s0 is the tortoise: nodes update it on every second start_s0 pulse after reset_nos. Stream s1 is the hare: nodes update it on every start_s1 pulse. The block sits between the host/config logic and the node array, compares the aggregated s0/s1 state vectors, and reports the attractor meeting index and period.

## Interface
Parameters:
- N_NODES, 8, width of aggregated node state vectors
- CNT_W, 16, width of step/period counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- start  in  1  begin run; sampled only in IDLE
- max_steps  in  CNT_W  step bound, captured on accepted start
- state_s0  in  N_NODES  concatenated s0 outputs of all nodes
- state_s1  in  N_NODES  concatenated s1 outputs of all nodes
- reset_nos  out  1  node init strobe (nodes load init_state)
- start_s0  out  1  tortoise update pulse to all nodes
- start_s1  out  1  hare update pulse to all nodes
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- timeout  out  1  last run hit max_steps; held until next accepted start
- meet_step  out  CNT_W  Floyd meeting index m = k/2; held
- period  out  CNT_W  attractor length λ; 0 on timeout; held

## Operation
- FSM states: IDLE, INIT, FIND, PERIOD, DONE.
- IDLE → INIT when start=1. On the transition: capture max_steps, clear k, cnt, timeout, meet_step and period.
- INIT, one cycle: reset_nos=1. Nodes load init_state, and the node pass bit is set, so the first start_s0 updates s0. INIT → FIND.
- FIND:
  - eq = (state_s0 == state_s1). match = eq && k[0]==0 && k≥2.
  - If match: no pulse, meet_step ← k>>1, → PERIOD.
  - Else if k==max_lat: no pulse, timeout ← 1, → DONE.
  - Else: start_s0 = start_s1 = 1, k ← k+1.
- PERIOD: s0 is held and only s1 advances.
  - If cnt≥1 && eq: period ← cnt, → DONE.
  - Else if cnt==max_lat: timeout ← 1, period ← 0, → DONE.
  - Else: start_s1 = 1, cnt ← cnt+1.
- DONE, one cycle: done=1, → IDLE.
- start_s0, start_s1 and done are combinational decodes of state and conditions. reset_nos, busy and all results are registered or state-decoded.
- start while busy is ignored. No abort input; rst is the only abort.
- Counters never wrap: the max_lat compare takes priority over increment. max_steps=0 gives immediate timeout in the first FIND cycle.

## Timing
- Reset (rst=0 at an edge): state=IDLE. All outputs 0: reset_nos, start_s0, start_s1, busy, done, timeout, meet_step, period.
- Reset mid-run: returns to IDLE on that edge and clears results. Node array state is don't-care until the next INIT.
- Node outputs reflect a pulse one cycle after it. The FSM compares registered node outputs in the cycle after each pulse edge, so no extra settle state is needed.
- Latency from start accepted at edge E0: INIT in cycle 1, FIND from cycle 2.
- Total cycles to done = 1 (INIT) + 2m + 1 (match cycle) + λ + 1 (detect cycle) + 1 (DONE).
- Simultaneous match and k==max_lat: match wins.

## Structure
- Shared package gnr_ctrl_pkg: FSM state encodings (IDLE..DONE) and default CNT_W.
- No sub-module required. The N_NODES-wide equality compare stays inline; if N_NODES grows beyond timing closure, factor it into gnr_state_cmp (registered compare, +1 cycle per check).

## Test plan
Bench uses a behavioural node-array model that honours pass semantics.
- Fixed point: init maps to itself, max_steps=100, start at cycle 0 -> reset_nos in cycle 1; pulses in cycles 2-3; start_s1 only in cycle 5; done in cycle 7; meet_step=1, period=1, timeout=0.
- 2-node toggle, init 01→10→01, max_steps=100 -> meet_step=2, period=2, timeout=0; busy high cycles 1..done.
- Transient 3 + cycle 5 (map over 8 states), max_steps=100 -> period=5; meet_step a multiple of 5 with meet_step ≥3; start_s0 never asserted in PERIOD.
- max_steps=3 on the cycle-5 network -> done with timeout=1, period=0, exactly 3 FIND pulses. max_steps=0 -> done 3 cycles after start, zero pulses.
- start held high through the run and through DONE -> exactly one run per IDLE visit, with the second run beginning the cycle after DONE. rst=0 during FIND -> next cycle busy=0, outputs 0, no done.

Source files
------------

// File: rtl/gnr_ctrl_pkg.sv
// Shared definitions for the gene-regulatory-network attractor sequencer.
// State encodings and default counter width.
package gnr_ctrl_pkg;

    localparam int CNT_W_DEF = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_FIND   = 3'd2;
    localparam logic [2:0] ST_PERIOD = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/gnr_attractor_ctrl.sv
// Floyd cycle-detection sequencer for the dual-trajectory node array.
// Drives init/update strobes and reports meeting index and period.
module gnr_attractor_ctrl
    import gnr_ctrl_pkg::*;
#(
    parameter int N_NODES = 8,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   max_steps,
    input  logic [N_NODES-1:0] state_s0,
    input  logic [N_NODES-1:0] state_s1,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   meet_step,
    output logic [CNT_W-1:0]   period
);

    logic [2:0]       state;
    logic [CNT_W-1:0] max_lat;
    logic [CNT_W-1:0] k;
    logic [CNT_W-1:0] cnt;

    logic eq;
    logic match;
    logic k_lim;
    logic per_hit;
    logic cnt_lim;
    logic in_find;
    logic in_per;

    // Node outputs are registered, so they already reflect last cycle's pulse.
    assign eq      = (state_s0 == state_s1);
    assign match   = eq && !k[0] && (k >= CNT_W'(2));
    assign k_lim   = (k == max_lat);
    assign per_hit = eq && (cnt != '0);
    assign cnt_lim = (cnt == max_lat);
    assign in_find = (state == ST_FIND);
    assign in_per  = (state == ST_PERIOD);

    assign start_s0  = in_find && !match && !k_lim;
    assign start_s1  = start_s0 || (in_per && !per_hit && !cnt_lim);
    assign reset_nos = (state == ST_INIT);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            max_lat   <= '0;
            k         <= '0;
            cnt       <= '0;
            timeout   <= 1'b0;
            meet_step <= '0;
            period    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_INIT;
                        max_lat   <= max_steps;
                        k         <= '0;
                        cnt       <= '0;
                        timeout   <= 1'b0;
                        meet_step <= '0;
                        period    <= '0;
                    end
                end
                ST_INIT: state <= ST_FIND;
                ST_FIND: begin
                    // Match is checked before the bound so a final-step hit still counts.
                    if (match) begin
                        meet_step <= k >> 1;
                        state     <= ST_PERIOD;
                    end else if (k_lim) begin
                        timeout <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        k <= k + CNT_W'(1);
                    end
                end
                ST_PERIOD: begin
                    if (per_hit) begin
                        period <= cnt;
                        state  <= ST_DONE;
                    end else if (cnt_lim) begin
                        timeout <= 1'b1;
                        period  <= '0;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Scoreboard bench for gnr_attractor_ctrl with a behavioural node array.
// Expected results come from iterating the network map directly.
module tb_gnr_attractor_ctrl;

    localparam int NN = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] max_steps = '0;
    logic [NN-1:0] state_s0 = '0;
    logic [NN-1:0] state_s1 = '0;
    logic          reset_nos;
    logic          start_s0;
    logic          start_s1;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] meet_step;
    logic [CW-1:0] period;

    gnr_attractor_ctrl #(.N_NODES(NN), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .max_steps (max_steps),
        .state_s0  (state_s0),
        .state_s1  (state_s1),
        .reset_nos (reset_nos),
        .start_s0  (start_s0),
        .start_s1  (start_s1),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .meet_step (meet_step),
        .period    (period)
    );

    always #5 clk = ~clk;

    typedef struct {
        int meet;
        int per;
        int tmo;
        int cyc;
        int n0;
        int n1;
    } exp_t;

    exp_t        sbq[$];
    exp_t        last_e;
    logic [7:0]  fmap [256];
    logic [7:0]  init_state = '0;
    logic        pass = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          tcyc = 0;
    int          last_done = -1;
    bit          held_mode = 1'b0;

    always @(posedge clk) tcyc <= tcyc + 1;

    // Node array: s0 advances on every second start_s0 after init, s1 on every start_s1.
    always @(posedge clk) begin
        if (reset_nos) begin
            state_s0 <= init_state;
            state_s1 <= init_state;
            pass     <= 1'b1;
        end else begin
            if (start_s0) begin
                if (pass) state_s0 <= fmap[state_s0];
                pass <= ~pass;
            end
            if (start_s1) state_s1 <= fmap[state_s1];
        end
    end

    task automatic chk(input string nm, input int act, input int want);
        n_chk++;
        if (act !== want)
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        else
            n_pass++;
    endtask

    // Floyd on the plain sequence x[i] = f^i(x0): tortoise at x[m], hare at x[2m].
    function automatic exp_t ref_run(input logic [7:0] x0, input int mx);
        exp_t       e;
        logic [7:0] x[$];
        int         m;
        int         lam;
        x.push_back(x0);
        for (int i = 0; i < 3 * mx + 4; i++) x.push_back(fmap[x[i]]);
        m = 0;
        for (int j = 1; 2 * j <= mx; j++) begin
            if (x[j] == x[2*j]) begin
                m = j;
                break;
            end
        end
        e.meet = m;
        e.per  = 0;
        e.tmo  = 1;
        if (m == 0) begin
            e.cyc = mx + 3;
            e.n0  = mx;
            e.n1  = mx;
            return e;
        end
        lam = 0;
        for (int c = 1; c <= mx; c++) begin
            if (x[2*m+c] == x[m]) begin
                lam = c;
                break;
            end
        end
        e.n0 = 2 * m;
        if (lam == 0) begin
            e.cyc = 2 * m + mx + 4;
            e.n1  = 2 * m + mx;
        end else begin
            e.tmo = 0;
            e.per = lam;
            e.cyc = 2 * m + lam + 4;
            e.n1  = 2 * m + lam;
        end
        return e;
    endfunction

    // Monitor: times each run from INIT and scores results on done.
    initial begin
        int   cyc;
        int   n0;
        int   n1;
        int   nb;
        bit   active;
        exp_t e;
        active = 1'b0;
        cyc = 0; n0 = 0; n1 = 0; nb = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                active = 1'b0;
            end else begin
                if (reset_nos) begin
                    if (held_mode && last_done >= 0)
                        chk("restart_gap", tcyc - last_done, 2);
                    active = 1'b1;
                    cyc = 1; n0 = 0; n1 = 0; nb = 0;
                end else if (active) begin
                    cyc++;
                end
                if (active) begin
                    n0 += int'(start_s0);
                    n1 += int'(start_s1);
                    nb += int'(busy);
                end
                if (done) begin
                    chk("done_has_expect", int'(sbq.size() != 0), 1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        chk("meet_step", int'(meet_step), e.meet);
                        chk("period", int'(period), e.per);
                        chk("timeout", int'(timeout), e.tmo);
                        chk("done_cycle", cyc, e.cyc);
                        chk("s0_pulses", n0, e.n0);
                        chk("s1_pulses", n1, e.n1);
                        chk("busy_cycles", nb, e.cyc);
                    end
                    active = 1'b0;
                    last_done = tcyc;
                end
            end
        end
    end

    task automatic set_identity();
        for (int i = 0; i < 256; i++) fmap[i] = 8'(i);
    endtask

    task automatic set_cycle5();
        set_identity();
        for (int i = 0; i < 7; i++) fmap[i] = 8'(i + 1);
        fmap[7] = 8'd3;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (!done && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", int'(done), 1);
    endtask

    task automatic run(input logic [7:0] x0, input int mx);
        init_state = x0;
        last_e = ref_run(x0, mx);
        sbq.push_back(last_e);
        @(negedge clk);
        start = 1'b1;
        max_steps = CW'(mx);
        @(negedge clk);
        start = 1'b0;
        wait_done(500);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_reset_nos"}, int'(reset_nos), 0);
        chk({tag, "_start_s0"}, int'(start_s0), 0);
        chk({tag, "_start_s1"}, int'(start_s1), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
        chk({tag, "_meet_step"}, int'(meet_step), 0);
        chk({tag, "_period"}, int'(period), 0);
    endtask

    initial begin
        int nd;
        set_identity();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("por");
        @(negedge clk);
        rst = 1'b1;

        set_identity();
        run(8'h5a, 100);

        set_identity();
        fmap[1] = 8'd2;
        fmap[2] = 8'd1;
        run(8'd1, 100);

        set_cycle5();
        run(8'd0, 100);
        run(8'd0, 3);
        run(8'd0, 0);

        for (int r = 0; r < 8; r++) begin
            set_identity();
            for (int i = 0; i < 16; i++) fmap[i] = 8'($urandom_range(0, 15));
            run(8'($urandom_range(0, 15)), int'($urandom_range(0, 40)));
        end

        // start held across two runs
        set_identity();
        fmap[1] = 8'd2;
        fmap[2] = 8'd1;
        init_state = 8'd1;
        last_e = ref_run(8'd1, 100);
        sbq.push_back(last_e);
        sbq.push_back(last_e);
        last_done = -1;
        held_mode = 1'b1;
        @(negedge clk);
        start = 1'b1;
        max_steps = CW'(100);
        wait_done(500);
        @(negedge clk);
        wait_done(500);
        start = 1'b0;
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            nd += int'(reset_nos);
        end
        held_mode = 1'b0;
        chk("held_extra_runs", nd, 0);
        chk("held_meet_step", int'(meet_step), last_e.meet);
        chk("held_period", int'(period), last_e.per);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_zero("idle_rst");
        @(negedge clk);
        rst = 1'b1;

        // abort in the middle of FIND
        set_cycle5();
        init_state = 8'd0;
        @(negedge clk);
        start = 1'b1;
        max_steps = CW'(100);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_in_find", int'(busy), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_zero("abort");
        @(negedge clk);
        rst = 1'b1;
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            nd += int'(done);
        end
        chk("no_done_after_abort", nd, 0);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
